// File: rtl/exec_stage_if.sv
// Decode->execute->memory handshake bundle for exec_stage.
// master drives the in_* request side and out_ready; slave is the execute stage.
interface exec_stage_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [W-1:0] in_valA;
  logic [W-1:0] in_valB;
  logic [W-1:0] in_valC;
  logic [3:0]   in_dstE;

  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic [3:0]   out_dstE;
  logic         out_cnd;
  logic         out_inv;

  modport master (
    output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, out_ready,
    input  in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_inv
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, out_ready,
    output in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_inv
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: operand select, add/sub/and/xor ALU, CC register, branch/cmov conditions, E/M register.
// Optional EXEC_PERF_EN adds perf_retired/perf_taken event counters.
module exec_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  exec_stage_if.slave bus,
  output logic [2:0] cc,
  output logic       halted
`ifdef EXEC_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_taken
`endif
);

  typedef enum logic [3:0] {
    I_HALT = 4'h0, I_NOP = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3,
    I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
    I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB
  } icode_e;

  typedef struct packed {
    logic [3:0]   icode;
    logic [W-1:0] valE;
    logic [W-1:0] valA;
    logic [3:0]   dstE;
    logic         cnd;
    logic         inv;
  } em_t;

  localparam logic [W-1:0] NEG8 = ~W'(7);
  localparam logic [W-1:0] POS8 = W'(8);

  em_t          em, em_nxt;
  logic         out_valid;
  logic         accept, pop;
  logic [W-1:0] alu_a, alu_b, b_op, sum, val_e;
  logic [1:0]   fn;
  logic         sub, alu_of, opq, opq_ok, is_cond, cond, cond_bad;
  logic         zf, sf, of;

  assign {zf, sf, of}  = cc;
  assign bus.in_ready  = ~halted & (~out_valid | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready & ~flush;
  assign pop           = out_valid & bus.out_ready;

  assign opq     = (bus.in_icode == I_OPQ);
  assign opq_ok  = opq & (bus.in_ifun <= 4'd3);
  assign is_cond = (bus.in_icode == I_CMOV) | (bus.in_icode == I_JXX);

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (bus.in_icode)
      I_OPQ, I_CMOV:             alu_a = bus.in_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = bus.in_valC;
      I_CALL, I_PUSH:            alu_a = NEG8;
      I_RET, I_POP:              alu_a = POS8;
      default:                   alu_a = '0;
    endcase
    case (bus.in_icode)
      I_OPQ, I_RMMOV, I_MRMOV, I_CALL, I_PUSH, I_RET, I_POP: alu_b = bus.in_valB;
      default:                                             alu_b = '0;
    endcase
  end

  // Shared add/subtract: B - A is B + ~A + 1; overflow uses the effective operand sign.
  assign fn     = opq_ok ? bus.in_ifun[1:0] : 2'd0;
  assign sub    = (fn == 2'd1);
  assign b_op   = sub ? ~alu_a : alu_a;
  assign sum    = alu_b + b_op + {{(W-1){1'b0}}, sub};
  assign alu_of = (alu_b[W-1] == b_op[W-1]) & (sum[W-1] != alu_b[W-1]);

  always_comb begin
    val_e = '0;
    case (fn)
      2'd0, 2'd1: val_e = sum;
      2'd2:       val_e = alu_b & alu_a;
      default:    val_e = alu_b ^ alu_a;
    endcase
    if (opq & ~opq_ok) val_e = '0;
  end

  // Conditions read the CC as it stands before this cycle's update.
  always_comb begin
    cond     = 1'b0;
    cond_bad = 1'b0;
    case (bus.in_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (sf ^ of) | zf;
      4'd2:    cond = sf ^ of;
      4'd3:    cond = zf;
      4'd4:    cond = ~zf;
      4'd5:    cond = ~(sf ^ of);
      4'd6:    cond = ~(sf ^ of) & ~zf;
      default: cond_bad = 1'b1;
    endcase
  end

  always_comb begin
    em_nxt       = '0;
    em_nxt.icode = bus.in_icode;
    em_nxt.valE  = val_e;
    em_nxt.valA  = bus.in_valA;
    em_nxt.cnd   = is_cond & cond;
    em_nxt.dstE  = ((bus.in_icode == I_CMOV) & ~cond) ? RNONE : bus.in_dstE;
    em_nxt.inv   = (opq & ~opq_ok) | (bus.in_icode > I_POP) | (is_cond & cond_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      em        <= '{icode: I_NOP, valE: '0, valA: '0, dstE: RNONE, cnd: 1'b0, inv: 1'b0};
      cc        <= 3'b100;
      halted    <= 1'b0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (pop)    out_valid <= 1'b0;
      if (accept) em <= em_nxt;
      if (accept & opq_ok) cc <= {val_e == '0, val_e[W-1], alu_of & (fn[1] == 1'b0)};
      if (accept & (bus.in_icode == I_HALT)) halted <= 1'b1;
    end
  end

`ifdef EXEC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_taken   <= '0;
    end else if (accept) begin
      perf_retired <= perf_retired + 32'd1;
      if ((bus.in_icode == I_JXX) & cond) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

  assign bus.out_valid = out_valid;
  assign bus.out_icode = em.icode;
  assign bus.out_valE  = em.valE;
  assign bus.out_valA  = em.valA;
  assign bus.out_dstE  = em.dstE;
  assign bus.out_cnd   = em.cnd;
  assign bus.out_inv   = em.inv;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized self-checking bench for exec_stage against an instruction-level reference model.
module tb_exec_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] cc;
  logic       halted;
  int         n_chk = 0;
  int         n_err = 0;

  exec_stage_if #(.W(64)) bus ();

`ifdef EXEC_PERF_EN
  logic [31:0] perf_retired, perf_taken;
  logic [31:0] m_ret, m_tak;
`endif

  exec_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .cc(cc), .halted(halted)
`ifdef EXEC_PERF_EN
    , .perf_retired(perf_retired), .perf_taken(perf_taken)
`endif
  );

  always #5 clk = ~clk;

  // reference state: what the E/M register, CC and halt flag should hold
  logic        m_vld, m_halt, m_cnd, m_inv;
  logic [2:0]  m_cc;
  logic [3:0]  m_icode, m_dst;
  logic [63:0] m_valE, m_valA;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_halt = 0; m_cnd = 0; m_inv = 0; m_cc = 3'b100;
    m_icode = 4'h1; m_dst = 4'hF; m_valE = 0; m_valA = 0;
`ifdef EXEC_PERF_EN
    m_ret = 0; m_tak = 0;
`endif
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_icode = 4'h1; bus.in_ifun = 0; bus.in_valA = 0;
    bus.in_valB = 0; bus.in_valC = 0; bus.in_dstE = 4'hF; bus.out_ready = 1; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_icode", bus.out_icode, 4'h1);
    chk("rst_valE", bus.out_valE, 0);
    chk("rst_dstE", bus.out_dstE, 4'hF);
    chk("rst_cc", cc, 3'b100);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic after();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, compare the DUT with the model, then advance the model.
  task automatic step(input logic v, input logic rdy, input logic fl, input logic [3:0] ic,
                      input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [3:0] d);
    logic        rdy_m, acc, zf, sf, ofl, cond, isc, of_n, opq_ok;
    logic [63:0] oa, ob, r;
    longint      sa, sb, sr;
    @(negedge clk);
    bus.in_valid = v; bus.in_icode = ic; bus.in_ifun = fn; bus.in_valA = a;
    bus.in_valB = b; bus.in_valC = c; bus.in_dstE = d; bus.out_ready = rdy; flush = fl;
    #1;
    rdy_m = !m_halt && (!m_vld || rdy);
    chk("in_ready", bus.in_ready, rdy_m);
    chk("out_valid", bus.out_valid, m_vld);
    chk("cc", cc, m_cc);
    chk("halted", halted, m_halt);
    if (m_vld) begin
      chk("out_icode", bus.out_icode, m_icode);
      chk("out_valE", bus.out_valE, m_valE);
      chk("out_valA", bus.out_valA, m_valA);
      chk("out_dstE", bus.out_dstE, m_dst);
      chk("out_cnd", bus.out_cnd, m_cnd);
      chk("out_inv", bus.out_inv, m_inv);
    end
`ifdef EXEC_PERF_EN
    chk("perf_retired", perf_retired, m_ret);
    chk("perf_taken", perf_taken, m_tak);
`endif
    acc = v && rdy_m && !fl;
    oa = 0;
    case (ic)
      4'h2, 4'h6:       oa = a;
      4'h3, 4'h4, 4'h5: oa = c;
      4'h8, 4'hA:       oa = -64'd8;
      4'h9, 4'hB:       oa = 64'd8;
      default:          oa = 0;
    endcase
    ob = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? b : 64'd0;
    opq_ok = (ic == 4'h6) && (fn <= 3);
    sa = oa; sb = ob;
    of_n = 0;
    r = ob + oa;
    if (ic == 4'h6) begin
      case (fn)
        4'd0: r = ob + oa;
        4'd1: r = ob - oa;
        4'd2: r = ob & oa;
        4'd3: r = ob ^ oa;
        default: r = 0;
      endcase
    end
    sr = r;
    if (opq_ok && fn == 0) of_n = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sb < 0));
    if (opq_ok && fn == 1) of_n = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sb < 0));
    {zf, sf, ofl} = m_cc;
    case (fn)
      4'd0: cond = 1;
      4'd1: cond = (sf ^ ofl) | zf;
      4'd2: cond = sf ^ ofl;
      4'd3: cond = zf;
      4'd4: cond = !zf;
      4'd5: cond = !(sf ^ ofl);
      4'd6: cond = !(sf ^ ofl) && !zf;
      default: cond = 0;
    endcase
    isc = (ic == 4'h2) || (ic == 4'h7);
    if (fl) m_vld = 0;
    else if (acc) m_vld = 1;
    else if (m_vld && rdy) m_vld = 0;
    if (acc) begin
      m_icode = ic; m_valE = r; m_valA = a;
      m_cnd = isc && cond;
      m_dst = (ic == 4'h2 && !cond) ? 4'hF : d;
      m_inv = (ic == 4'h6 && fn > 3) || ic > 4'hB || (isc && fn > 6);
      if (opq_ok) m_cc = {r == 0, r[63], of_n};
      if (ic == 4'h0) m_halt = 1;
`ifdef EXEC_PERF_EN
      m_ret++;
      if (ic == 4'h7 && cond) m_tak++;
`endif
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0]  ic, fn;
    logic [63:0] a, b;
    idle_inputs();
    model_reset();
    do_reset();
    chk("idle_in_ready", bus.in_ready, 1);

    // signed overflow on subtract
    step(1, 1, 0, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h3);
    after();
    chk("sub_valE", bus.out_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_cc", cc, 3'b001);

    // add to zero, then jXX on ZF
    step(1, 1, 0, 4'h6, 4'h0, 64'd5, -64'd5, 0, 4'h3);
    after();
    chk("add_valE", bus.out_valE, 0);
    chk("add_cc", cc, 3'b100);
    step(1, 1, 0, 4'h7, 4'h3, 0, 0, 64'h100, 4'hF);
    after();
    chk("jxx_cnd", bus.out_cnd, 1);

    // not-taken cmov drops its destination
    step(1, 1, 0, 4'h2, 4'h2, 64'h1234, 0, 0, 4'h2);
    after();
    chk("cmov_cnd", bus.out_cnd, 0);
    chk("cmov_dstE", bus.out_dstE, 4'hF);
    chk("cmov_valE", bus.out_valE, 64'h1234);

    // back-pressure then simultaneous pop and accept
    repeat (3) step(1, 0, 0, 4'h6, 4'h0, 64'd1, 64'd2, 0, 4'h5);
    after();
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_hold", bus.out_valE, 64'h1234);
    step(1, 1, 0, 4'h6, 4'h0, 64'd1, 64'd2, 0, 4'h5);
    after();
    chk("pop_acc_valid", bus.out_valid, 1);
    chk("pop_acc_valE", bus.out_valE, 64'd3);

    // flush kills both the held result and the concurrent accept
    step(1, 1, 1, 4'h6, 4'h0, 64'd5, -64'd5, 0, 4'h5);
    after();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_cc", cc, 3'b000);

    // HALT blocks further input
    step(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 4'hF);
    step(1, 1, 0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1);
    after();
    chk("halt_flag", halted, 1);
    chk("halt_in_ready", bus.in_ready, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0 || (m_halt && $urandom_range(0, 9) == 0)) do_reset();
      ic = 4'($urandom_range(0, 15));
      if (ic == 4'h0 && $urandom_range(0, 15) != 0) ic = 4'h6;
      fn = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      b = rnd64();
      a = ($urandom_range(0, 3) == 0) ? b : rnd64();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           ic, fn, a, b, rnd64(), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
